// File: rtl/add_round_key_param.sv
// add_round_key_param: XORs one expanded-key round into the in-place AES state.
// Each column is processed as NROWS/2 read/write pairs. Each pair reads two
// state words and two key bytes together, then writes both XOR results back
// on the next cycle. The two memory ports are generated as identical lanes.
// A lane differs from the other only in its row offset (0 or 1).

// One memory-port lane: forms addresses and write data for row r+ROW_OFS.
// It drives zero on every output whenever its port is not in use.
module add_round_key_param_lane #(
  parameter int DATA_W     = 32,
  parameter int KEY_W      = 8,
  parameter int NB         = 4,
  parameter int NROWS      = 4,
  parameter int ADDR_W     = 5,
  parameter int KEY_ADDR_W = 9,
  parameter int KEY_STRIDE = 120,
  parameter int JW         = 3,
  parameter int RW         = 3,
  parameter int ROW_OFS    = 0
)(
  input  logic                  rd,
  input  logic                  wr,
  input  logic [JW-1:0]         j,
  input  logic [RW-1:0]         r,
  input  logic [5:0]            n_reg,
  input  logic [DATA_W-1:0]     q,
  input  logic [KEY_W-1:0]      kq,
  output logic [ADDR_W-1:0]     addr,
  output logic                  ce,
  output logic                  we,
  output logic [DATA_W-1:0]     d,
  output logic [KEY_ADDR_W-1:0] kaddr,
  output logic                  kce
);

  logic [ADDR_W-1:0]     st_addr;
  logic [KEY_ADDR_W-1:0] key_addr;

  // Address arithmetic wraps modulo 2^width by construction.
  assign st_addr  = ADDR_W'(j) * ADDR_W'(NROWS) + ADDR_W'(r) + ADDR_W'(ROW_OFS);
  assign key_addr = (KEY_ADDR_W'(r) + KEY_ADDR_W'(ROW_OFS)) * KEY_ADDR_W'(KEY_STRIDE)
                  + KEY_ADDR_W'(n_reg) * KEY_ADDR_W'(NB) + KEY_ADDR_W'(j);

  // Port drive: read cycle fetches state and key, write cycle stores the XOR.
  always_comb begin
    addr  = '0;
    ce    = 1'b0;
    we    = 1'b0;
    d     = '0;
    kaddr = '0;
    kce   = 1'b0;
    if (rd) begin
      addr  = st_addr;
      ce    = 1'b1;
      kaddr = key_addr;
      kce   = 1'b1;
    end else if (wr) begin
      addr = st_addr;
      ce   = 1'b1;
      we   = 1'b1;
      d    = q ^ DATA_W'(kq);
    end
  end

endmodule

module add_round_key_param #(
  parameter int DATA_W     = 32,
  parameter int KEY_W      = 8,
  parameter int NB         = 4,
  parameter int NROWS      = 4,
  parameter int ADDR_W     = 5,
  parameter int KEY_ADDR_W = 9,
  parameter int KEY_STRIDE = 120,
  parameter int NR_MAX     = 14
)(
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  output logic                  ap_err,
  input  logic [5:0]            n,
  output logic [ADDR_W-1:0]     statemt_address0,
  output logic                  statemt_ce0,
  output logic                  statemt_we0,
  output logic [DATA_W-1:0]     statemt_d0,
  input  logic [DATA_W-1:0]     statemt_q0,
  output logic [ADDR_W-1:0]     statemt_address1,
  output logic                  statemt_ce1,
  output logic                  statemt_we1,
  output logic [DATA_W-1:0]     statemt_d1,
  input  logic [DATA_W-1:0]     statemt_q1,
  output logic [KEY_ADDR_W-1:0] key_address0,
  output logic                  key_ce0,
  input  logic [KEY_W-1:0]      key_q0,
  output logic [KEY_ADDR_W-1:0] key_address1,
  output logic                  key_ce1,
  input  logic [KEY_W-1:0]      key_q1
);

  localparam int JW     = $clog2(NB + 1);
  localparam int RW     = $clog2(NROWS + 1);
  localparam int NPORTS = 2;

  // Reject configurations the datapath cannot address.
  if (NB < 1 || NB > 16 || NROWS < 2 || NROWS > 8 || (NROWS % 2) != 0 ||
      NB * NROWS > (1 << ADDR_W)) begin : g_bad_cfg
    $error("add_round_key_param: unsupported NB/NROWS/ADDR_W combination");
  end

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_COL  = 4'b0010,
    S_RD   = 4'b0100,
    S_WR   = 4'b1000
  } state_t;

  state_t          state, state_nxt;
  logic [JW-1:0]   j;
  logic [RW-1:0]   r;
  logic [5:0]      n_reg;
  logic            err;
  logic            col_end, row_last, n_bad;

  assign col_end  = (j == JW'(NB));
  assign row_last = (32'(r) + 32'd2 == 32'(NROWS));
  assign n_bad    = (32'(n) > 32'(NR_MAX));
  assign ap_err   = err;

  // State register; reset aborts any run immediately.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    ap_done   = 1'b0;
    ap_ready  = 1'b0;
    ap_idle   = 1'b0;
    case (state)
      S_IDLE: begin
        ap_idle = !ap_start;
        if (ap_start) state_nxt = S_COL;
      end
      S_COL: begin
        if (col_end) begin
          ap_done   = 1'b1;
          ap_ready  = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RD;
        end
      end
      S_RD:    state_nxt = S_WR;
      S_WR:    state_nxt = row_last ? S_COL : S_RD;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Column/row counters, round latch and error flag. An out-of-range round
  // preloads j=NB so the first column check finishes the run untouched.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      j     <= '0;
      r     <= '0;
      n_reg <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ap_start) begin
          n_reg <= n;
          err   <= n_bad;
          j     <= n_bad ? JW'(NB) : '0;
        end
        S_COL: if (!col_end) r <= '0;
        S_WR: begin
          if (row_last) j <= j + 1'b1;
          else          r <= r + RW'(2);
        end
        default: ;
      endcase
    end
  end

  logic [NPORTS-1:0][ADDR_W-1:0]     s_addr;
  logic [NPORTS-1:0]                 s_ce, s_we, k_ce;
  logic [NPORTS-1:0][DATA_W-1:0]     s_d, s_q;
  logic [NPORTS-1:0][KEY_ADDR_W-1:0] k_addr;
  logic [NPORTS-1:0][KEY_W-1:0]      k_q;

  assign s_q[0] = statemt_q0;
  assign s_q[1] = statemt_q1;
  assign k_q[0] = key_q0;
  assign k_q[1] = key_q1;

  for (genvar p = 0; p < NPORTS; p++) begin : g_lane
    add_round_key_param_lane #(
      .DATA_W(DATA_W), .KEY_W(KEY_W), .NB(NB), .NROWS(NROWS),
      .ADDR_W(ADDR_W), .KEY_ADDR_W(KEY_ADDR_W), .KEY_STRIDE(KEY_STRIDE),
      .JW(JW), .RW(RW), .ROW_OFS(p)
    ) u_lane (
      .rd    (state == S_RD),
      .wr    (state == S_WR),
      .j     (j),
      .r     (r),
      .n_reg (n_reg),
      .q     (s_q[p]),
      .kq    (k_q[p]),
      .addr  (s_addr[p]),
      .ce    (s_ce[p]),
      .we    (s_we[p]),
      .d     (s_d[p]),
      .kaddr (k_addr[p]),
      .kce   (k_ce[p])
    );
  end

  assign statemt_address0 = s_addr[0];
  assign statemt_address1 = s_addr[1];
  assign statemt_ce0      = s_ce[0];
  assign statemt_ce1      = s_ce[1];
  assign statemt_we0      = s_we[0];
  assign statemt_we1      = s_we[1];
  assign statemt_d0       = s_d[0];
  assign statemt_d1       = s_d[1];
  assign key_address0     = k_addr[0];
  assign key_address1     = k_addr[1];
  assign key_ce0          = k_ce[0];
  assign key_ce1          = k_ce[1];

endmodule
